// File: rtl/bus_fifo_pkg.sv
// Shared constants for the memory-mapped FIFO port: register offsets,
// STATUS bit positions and the default base address.
package bus_fifo_pkg;

  localparam logic [1:0] OFS_TXDATA = 2'd0;
  localparam logic [1:0] OFS_RXDATA = 2'd1;
  localparam logic [1:0] OFS_STATUS = 2'd2;
  localparam logic [1:0] OFS_COUNT  = 2'd3;

  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_RX_FULL  = 2;
  localparam int ST_RX_EMPTY = 3;
  localparam int ST_TX_OVF   = 4;
  localparam int ST_RX_UDF   = 5;
  localparam int ST_IRQ      = 6;

  localparam logic [15:0] DEFAULT_BASE_ADDR = 16'h1000;

endpackage

// File: rtl/bus_fifo_port_if.sv
// Processor data-bus and TX/RX valid/ready signals of the FIFO port.
// master = processor/environment side, slave = the peripheral.
interface bus_fifo_port_if;
  logic [15:0] ADDR;
  logic [15:0] DOUT;
  logic        W;
  logic [15:0] rdata;
  logic        hit;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;

  modport master (
    output ADDR, DOUT, W, tx_ready, rx_data, rx_valid,
    input  rdata, hit, tx_data, tx_valid, rx_ready
  );

  modport slave (
    input  ADDR, DOUT, W, tx_ready, rx_data, rx_valid,
    output rdata, hit, tx_data, tx_valid, rx_ready
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with simultaneous push/pop; head reads 0 while empty.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CNT_FULL);
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  assign head  = empty ? '0 : mem_q[rd_ptr_q];
  assign count = count_q;

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: stale words are never visible through head.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end
endmodule

// File: rtl/bus_fifo_port.sv
// Memory-mapped TX/RX FIFO peripheral on the processor data bus.
// Optional interrupt output enabled by defining FIFO_PORT_IRQ_EN.
module bus_fifo_port
  import bus_fifo_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int          DEPTH     = 8
) (
  input  logic            Clock,
  input  logic            Reset,
  bus_fifo_port_if.slave  bus
`ifdef FIFO_PORT_IRQ_EN
  ,
  output logic            irq
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          sel, wr;
  logic [1:0]    ofs;
  logic          tx_push, tx_pop, rx_push, rx_pop;
  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic [15:0]   tx_head, rx_head;
  logic [CW-1:0] tx_count, rx_count;
  logic [15:0]   status;
  logic [15:0]   rdata_q, rdata_d;
  logic          hit_q, hit_d;
  logic          tx_ovf_q, tx_ovf_d, rx_udf_q, rx_udf_d;
  logic          irq_val;

  always_comb begin
    sel     = (bus.ADDR[15:2] == BASE_ADDR[15:2]);
    ofs     = bus.ADDR[1:0];
    wr      = bus.W & sel;
    tx_push = wr & (ofs == OFS_TXDATA);
    tx_pop  = ~tx_empty & bus.tx_ready;
    rx_pop  = wr & (ofs == OFS_RXDATA);
    rx_push = bus.rx_valid & ~rx_full;
  end

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(16)) u_tx_fifo (
    .clk(Clock), .srst(Reset),
    .push(tx_push), .push_data(bus.DOUT), .pop(tx_pop),
    .head(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(16)) u_rx_fifo (
    .clk(Clock), .srst(Reset),
    .push(rx_push), .push_data(bus.rx_data), .pop(rx_pop),
    .head(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  assign bus.tx_data  = tx_head;
  assign bus.tx_valid = ~tx_empty;
  assign bus.rx_ready = ~rx_full;

  // A flag raised in the same cycle as its W1C clear stays set.
  always_comb begin
    tx_ovf_d = tx_ovf_q;
    rx_udf_d = rx_udf_q;
    if (wr && ofs == OFS_STATUS && bus.DOUT[ST_TX_OVF]) tx_ovf_d = 1'b0;
    if (wr && ofs == OFS_STATUS && bus.DOUT[ST_RX_UDF]) rx_udf_d = 1'b0;
    if (tx_push && tx_full && !tx_pop) tx_ovf_d = 1'b1;
    if (rx_pop && rx_empty)            rx_udf_d = 1'b1;
  end

`ifdef FIFO_PORT_IRQ_EN
  logic irq_q, irq_d;
  assign irq_d   = ~rx_empty | tx_ovf_q | rx_udf_q;
  assign irq_val = irq_q;
  assign irq     = irq_q;
  always_ff @(posedge Clock) begin
    if (Reset) irq_q <= 1'b0;
    else       irq_q <= irq_d;
  end
`else
  assign irq_val = 1'b0;
`endif

  always_comb begin
    status              = '0;
    status[ST_TX_FULL]  = tx_full;
    status[ST_TX_EMPTY] = tx_empty;
    status[ST_RX_FULL]  = rx_full;
    status[ST_RX_EMPTY] = rx_empty;
    status[ST_TX_OVF]   = tx_ovf_q;
    status[ST_RX_UDF]   = rx_udf_q;
    status[ST_IRQ]      = irq_val;
    hit_d   = sel;
    rdata_d = '0;
    if (sel) begin
      case (ofs)
        OFS_RXDATA: rdata_d = rx_head;
        OFS_STATUS: rdata_d = status;
        OFS_COUNT:  rdata_d = {8'(rx_count), 8'(tx_count)};
        default:    rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      rdata_q  <= '0;
      hit_q    <= 1'b0;
      tx_ovf_q <= 1'b0;
      rx_udf_q <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      hit_q    <= hit_d;
      tx_ovf_q <= tx_ovf_d;
      rx_udf_q <= rx_udf_d;
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.hit   = hit_q;
endmodule

// File: tb/tb_bus_fifo_port.sv
// Directed self-checking bench for bus_fifo_port (default build, DEPTH=8).
module tb_bus_fifo_port;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_total = 0;
  int   n_pass  = 0;
  logic [15:0] rd_val;

  bus_fifo_port_if bus();

`ifdef FIFO_PORT_IRQ_EN
  logic irq;
  bus_fifo_port #(.BASE_ADDR(16'h1000), .DEPTH(8)) dut (
    .Clock(clk), .Reset(rst), .bus(bus), .irq(irq));
`else
  bus_fifo_port #(.BASE_ADDR(16'h1000), .DEPTH(8)) dut (
    .Clock(clk), .Reset(rst), .bus(bus));
`endif

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [15:0] addr, input logic [15:0] data);
    bus.ADDR = addr; bus.DOUT = data; bus.W = 1'b1;
    tick();
    bus.W = 1'b0;
    $display("wr  addr=%h data=%h", addr, data);
  endtask

  task automatic bus_rd(input logic [15:0] addr, output logic [15:0] data);
    bus.ADDR = addr;
    tick();
    data = bus.rdata;
    $display("rd  addr=%h data=%h hit=%b", addr, data, bus.hit);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    n_total++; if (bus.tx_valid !== 1'b0) $display("FAIL rst_tx_valid: got %b expected 0", bus.tx_valid); else n_pass++;
    n_total++; if (bus.rx_ready !== 1'b1) $display("FAIL rst_rx_ready: got %b expected 1", bus.rx_ready); else n_pass++;
    n_total++; if (bus.tx_data !== 16'h0) $display("FAIL rst_tx_data: got %h expected 0000", bus.tx_data); else n_pass++;
    n_total++; if ({bus.hit, bus.rdata} !== 17'h0) $display("FAIL rst_rdata_hit: got %h expected 00000", {bus.hit, bus.rdata}); else n_pass++;
    bus_rd(16'h1002, rd_val);
    n_total++; if (rd_val !== 16'h000A) $display("FAIL reset_status: got %h expected 000a", rd_val); else n_pass++;
    n_total++; if (bus.hit !== 1'b1) $display("FAIL status_hit: got %b expected 1", bus.hit); else n_pass++;
    bus_rd(16'h2002, rd_val);
    n_total++; if ({bus.hit, rd_val} !== 17'h0) $display("FAIL miss_decode: got %h expected 00000", {bus.hit, rd_val}); else n_pass++;
  endtask

  task automatic test_tx_basic();
    bus_wr(16'h1000, 16'h1234);
    bus_wr(16'h1000, 16'hBEEF);
    bus_rd(16'h1003, rd_val);
    n_total++; if (rd_val !== 16'h0002) $display("FAIL tx_count2: got %h expected 0002", rd_val); else n_pass++;
    bus_rd(16'h1000, rd_val);
    n_total++; if (rd_val !== 16'h0000) $display("FAIL txdata_read: got %h expected 0000", rd_val); else n_pass++;
    bus.tx_ready = 1'b1;
    n_total++; if (bus.tx_data !== 16'h1234) $display("FAIL tx_head0: got %h expected 1234", bus.tx_data); else n_pass++;
    tick();
    n_total++; if (bus.tx_data !== 16'hBEEF) $display("FAIL tx_head1: got %h expected beef", bus.tx_data); else n_pass++;
    tick();
    n_total++; if (bus.tx_valid !== 1'b0) $display("FAIL tx_drained: got %b expected 0", bus.tx_valid); else n_pass++;
    bus.tx_ready = 1'b0;
  endtask

  task automatic test_tx_overflow();
    // One word parked in RX so rx_empty reads 0 during this test
    bus.rx_data = 16'h0077; bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
    for (int i = 0; i < 9; i++) bus_wr(16'h1000, 16'hA000 + 16'(i));
    bus_rd(16'h1002, rd_val);
    n_total++; if (rd_val !== 16'h0011) $display("FAIL tx_ovf_status: got %h expected 0011", rd_val); else n_pass++;
    bus_wr(16'h1002, 16'h0010);
    bus_rd(16'h1002, rd_val);
    n_total++; if (rd_val !== 16'h0001) $display("FAIL tx_ovf_clear: got %h expected 0001", rd_val); else n_pass++;
    // Full TX drained while a write arrives: accepted, no overflow
    bus.ADDR = 16'h1000; bus.DOUT = 16'hC0DE; bus.W = 1'b1; bus.tx_ready = 1'b1;
    tick();
    bus.W = 1'b0; bus.tx_ready = 1'b0;
    bus_rd(16'h1002, rd_val);
    n_total++; if (rd_val !== 16'h0001) $display("FAIL full_push_pop: got %h expected 0001", rd_val); else n_pass++;
    bus_rd(16'h1003, rd_val);
    n_total++; if (rd_val !== 16'h0108) $display("FAIL count_full: got %h expected 0108", rd_val); else n_pass++;
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic [15:0] exp_w;
      exp_w = (i == 7) ? 16'hC0DE : 16'hA001 + 16'(i);
      n_total++; if (bus.tx_data !== exp_w) $display("FAIL tx_drain_%0d: got %h expected %h", i, bus.tx_data, exp_w); else n_pass++;
      tick();
    end
    bus.tx_ready = 1'b0;
    n_total++; if (bus.tx_valid !== 1'b0) $display("FAIL tx_empty_after: got %b expected 0", bus.tx_valid); else n_pass++;
    bus_wr(16'h1001, 16'h0000);
  endtask

  task automatic test_rx_basic();
    bus.rx_valid = 1'b1; bus.rx_data = 16'h00AA;
    tick();
    bus.rx_data = 16'h00BB;
    tick();
    bus.rx_valid = 1'b0;
    bus_rd(16'h1001, rd_val);
    n_total++; if (rd_val !== 16'h00AA) $display("FAIL rx_head0: got %h expected 00aa", rd_val); else n_pass++;
    bus_rd(16'h1001, rd_val);
    n_total++; if (rd_val !== 16'h00AA) $display("FAIL rx_no_pop: got %h expected 00aa", rd_val); else n_pass++;
    bus_wr(16'h1001, 16'hFFFF);
    bus_rd(16'h1001, rd_val);
    n_total++; if (rd_val !== 16'h00BB) $display("FAIL rx_head1: got %h expected 00bb", rd_val); else n_pass++;
    bus_wr(16'h1001, 16'h0000);
    bus_rd(16'h1001, rd_val);
    n_total++; if (rd_val !== 16'h0000) $display("FAIL rx_empty_read: got %h expected 0000", rd_val); else n_pass++;
  endtask

  task automatic test_rx_full();
    bus.rx_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.rx_data = 16'h0100 + 16'(i);
      tick();
    end
    bus.rx_data = 16'h01FF;
    n_total++; if (bus.rx_ready !== 1'b0) $display("FAIL rx_full_ready: got %b expected 0", bus.rx_ready); else n_pass++;
    tick(); tick();
    bus_rd(16'h1003, rd_val);
    n_total++; if (rd_val !== 16'h0800) $display("FAIL rx_count_held: got %h expected 0800", rd_val); else n_pass++;
    bus_wr(16'h1001, 16'h0000);
    n_total++; if (bus.rx_ready !== 1'b1) $display("FAIL rx_ready_after_pop: got %b expected 1", bus.rx_ready); else n_pass++;
    tick();
    bus.rx_valid = 1'b0;
    n_total++; if (bus.rx_ready !== 1'b0) $display("FAIL rx_refill: got %b expected 0", bus.rx_ready); else n_pass++;
    bus_rd(16'h1001, rd_val);
    n_total++; if (rd_val !== 16'h0101) $display("FAIL rx_head_after_pop: got %h expected 0101", rd_val); else n_pass++;
    for (int i = 0; i < 7; i++) bus_wr(16'h1001, 16'h0000);
    bus_rd(16'h1001, rd_val);
    n_total++; if (rd_val !== 16'h01FF) $display("FAIL rx_last_word: got %h expected 01ff", rd_val); else n_pass++;
    bus_wr(16'h1001, 16'h0000);
  endtask

  task automatic test_rx_underflow();
    bus_wr(16'h1001, 16'h0000);
    bus_rd(16'h1002, rd_val);
    n_total++; if (rd_val !== 16'h002A) $display("FAIL rx_udf_status: got %h expected 002a", rd_val); else n_pass++;
    bus_wr(16'h1002, 16'h0020);
    bus_rd(16'h1002, rd_val);
    n_total++; if (rd_val !== 16'h000A) $display("FAIL rx_udf_clear: got %h expected 000a", rd_val); else n_pass++;
    // Empty RX: external push and processor pop together
    bus.ADDR = 16'h1001; bus.W = 1'b1; bus.rx_valid = 1'b1; bus.rx_data = 16'h0055;
    tick();
    bus.W = 1'b0; bus.rx_valid = 1'b0;
    bus_rd(16'h1002, rd_val);
    n_total++; if (rd_val !== 16'h0022) $display("FAIL rx_push_pop_empty: got %h expected 0022", rd_val); else n_pass++;
    bus_rd(16'h1001, rd_val);
    n_total++; if (rd_val !== 16'h0055) $display("FAIL rx_push_kept: got %h expected 0055", rd_val); else n_pass++;
    bus_wr(16'h1001, 16'h0000);
    bus_wr(16'h1002, 16'h0030);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) bus_wr(16'h1000, 16'h5000 + 16'(i));
    bus_wr(16'h1001, 16'h0000);
    bus.tx_ready = 1'b1; bus.rx_valid = 1'b1; bus.rx_data = 16'h0999;
    rst = 1'b1;
    tick();
    rst = 1'b0; bus.tx_ready = 1'b0; bus.rx_valid = 1'b0;
    n_total++; if (bus.tx_valid !== 1'b0) $display("FAIL mid_rst_tx_valid: got %b expected 0", bus.tx_valid); else n_pass++;
    n_total++; if (bus.rx_ready !== 1'b1) $display("FAIL mid_rst_rx_ready: got %b expected 1", bus.rx_ready); else n_pass++;
    bus_rd(16'h1003, rd_val);
    n_total++; if (rd_val !== 16'h0000) $display("FAIL mid_rst_count: got %h expected 0000", rd_val); else n_pass++;
    bus_rd(16'h1002, rd_val);
    n_total++; if (rd_val !== 16'h000A) $display("FAIL mid_rst_status: got %h expected 000a", rd_val); else n_pass++;
  endtask

  initial begin
    bus.ADDR = 16'h0000; bus.DOUT = 16'h0000; bus.W = 1'b0;
    bus.tx_ready = 1'b0; bus.rx_data = 16'h0000; bus.rx_valid = 1'b0;
    test_reset();
    test_tx_basic();
    test_tx_overflow();
    test_rx_basic();
    test_rx_full();
    test_rx_underflow();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
